// File: rtl/dmem_access_pkg.sv
`default_nettype none
//==============================================================================
// Module : dmem_access_pkg
// Brief  : Shared access-width encoding, FSM states and helpers for dmem_access.
// Rev    : 1.0 - initial release
//==============================================================================
package dmem_access_pkg;

    // Same width encoding the store byte-enable generator uses.
    localparam logic [1:0] ACC_WORD = 2'd0;
    localparam logic [1:0] ACC_HALF = 2'd1;
    localparam logic [1:0] ACC_BYTE = 2'd2;
    localparam logic [1:0] ACC_ILL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [31:0] replicate_wdata(input logic [1:0]  width,
                                                    input logic [31:0] wdata);
        logic [31:0] rep;
        case (width)
            ACC_HALF: rep = {2{wdata[15:0]}};
            ACC_BYTE: rep = {4{wdata[7:0]}};
            default:  rep = wdata;
        endcase
        return rep;
    endfunction

    function automatic logic is_illegal(input logic [1:0] width,
                                        input logic [1:0] addr_lo,
                                        input logic       ld,
                                        input logic       st);
        logic bad;
        bad = ld && st;
        case (width)
            ACC_WORD: bad = bad || (addr_lo != 2'b00);
            ACC_HALF: bad = bad || addr_lo[0];
            ACC_BYTE: bad = bad;
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_load_extend.sv
`default_nettype none
//==============================================================================
// Module : dmem_access_load_extend
// Brief  : Combinational lane select and sign/zero extension of a loaded word.
// Rev    : 1.0 - initial release
//==============================================================================
module dmem_access_load_extend
    import dmem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  width,
    input  logic        sign,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr_lo)
            2'd0: w_byte = rdata[7:0];
            2'd1: w_byte = rdata[15:8];
            2'd2: w_byte = rdata[23:16];
            2'd3: w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase

        // Halves are only ever legal at offset 0 or 2.
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (width)
            ACC_BYTE: result = {{24{sign & w_byte[7]}}, w_byte};
            ACC_HALF: result = {{16{sign & w_half[15]}}, w_half};
            default:  result = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_access.sv
`default_nettype none
//==============================================================================
// Module : dmem_access
// Brief  : MEM-stage data-memory access unit with single-outstanding req/ack port.
// Rev    : 1.0 - initial release
//==============================================================================
module dmem_access
    import dmem_access_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit ZERO_ON_EXC = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [1:0]        store_type,
    input  logic              load_sign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic [31:0]       out_rdata,
    output logic              access_exc
);

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_is_load;
    logic [1:0]        r_width;
    logic              r_sign;
    logic [1:0]        r_addr_lo;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-3:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic              r_out_valid;
    logic [31:0]       r_out_rdata;
    logic              r_access_exc;

    logic              w_accept;
    logic              w_illegal;
    logic              w_noop;
    logic              w_ack;
    logic [31:0]       w_load_data;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_illegal = is_illegal(store_type, addr[1:0], is_load, is_store);
    assign w_noop    = !is_load && !is_store;
    assign w_ack     = (r_state == ST_REQ) && mem_ack;

    assign in_ready   = (r_state == ST_IDLE);
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;
    assign out_valid  = r_out_valid;
    assign out_rdata  = r_out_rdata;
    assign access_exc = r_access_exc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_illegal || w_noop) ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    dmem_access_load_extend u_load_extend (
        .rdata   (mem_rdata),
        .addr_lo (r_addr_lo),
        .width   (r_width),
        .sign    (r_sign),
        .result  (w_load_data)
    );

    // out_valid/access_exc are set on the transition into RESP, so they are
    // high for exactly the one cycle spent in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_load    <= 1'b0;
            r_width      <= ACC_WORD;
            r_sign       <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= 4'b0000;
            r_mem_wdata  <= 32'h0;
            r_out_valid  <= 1'b0;
            r_out_rdata  <= 32'h0;
            r_access_exc <= 1'b0;
        end else begin
            r_out_valid  <= 1'b0;
            r_access_exc <= 1'b0;

            if (w_accept) begin
                r_is_load <= is_load;
                r_width   <= store_type;
                r_sign    <= load_sign;
                r_addr_lo <= addr[1:0];
                if (w_illegal) begin
                    r_out_valid  <= 1'b1;
                    r_access_exc <= 1'b1;
                    if (ZERO_ON_EXC) begin
                        r_out_rdata <= 32'h0;
                    end
                end else if (w_noop) begin
                    r_out_valid <= 1'b1;
                    r_out_rdata <= 32'h0;
                end else begin
                    // The be input is trusted only once the access is known legal.
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= is_store;
                    r_mem_addr  <= addr[ADDR_W-1:2];
                    r_mem_be    <= is_store ? be : 4'b1111;
                    r_mem_wdata <= is_store ? replicate_wdata(store_type, wdata) : 32'h0;
                end
            end

            if (w_ack) begin
                r_mem_req   <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_be    <= 4'b0000;
                r_out_valid <= 1'b1;
                r_out_rdata <= r_is_load ? w_load_data : 32'h0;
            end
        end
    end

endmodule
`default_nettype wire
